// File: rtl/branch_resolve_if.sv
// branch_resolve_if
//   Bundles the decode-side branch handshake, the flag-writer bookkeeping
//   signals and the resolution outputs of branch_resolve.
//
//   Handshake: decode raises br_valid with br_cond/br_target and holds all
//   three stable until it sees the one-cycle br_ack pulse; br_taken,
//   redirect_valid and redirect_pc are meaningful only while br_ack is high.
//   A new branch may be presented during the ack cycle; it is accepted on
//   the following cycle.
//
//   master : fetch/decode + flag register side (drives requests and flags)
//   slave  : branch_resolve
interface branch_resolve_if #(
    parameter int PC_W = 16
);
    logic            br_valid;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic            flag_wr_issue;
    logic            flag_en;
    logic [2:0]      flag_d;
    logic [2:0]      flags;
    logic            br_stall;
    logic            br_ack;
    logic            br_taken;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            issue_full;

    modport master (
        output br_valid, br_cond, br_target, flag_wr_issue, flag_en, flag_d, flags,
        input  br_stall, br_ack, br_taken, redirect_valid, redirect_pc, issue_full
    );

    modport slave (
        input  br_valid, br_cond, br_target, flag_wr_issue, flag_en, flag_d, flags,
        output br_stall, br_ack, br_taken, redirect_valid, redirect_pc, issue_full
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve
//   Resolves conditional branches against the {N,V,Z} flag register. Counts
//   in-flight flag writers; a branch that arrives while writers are pending
//   waits until exactly those writers have retired, then evaluates its
//   condition and pulses br_ack (plus redirect_valid when taken).
//
//   Ports:
//     clk, rst   - clock, asynchronous active-high reset
//     bus        - branch_resolve_if.slave (request, flag bookkeeping, results)
//     state_dbg  - current FSM state (0 IDLE, 1 WAIT, 2 RESOLVE)
//
//   Optional: define BR_FLAG_FWD_EN to evaluate on flag_d in the cycle the
//   last awaited writer retires, saving one cycle of branch latency.
module branch_resolve #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolve_if.slave    bus,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] wait_q, wait_n;
    logic [2:0]       cond_q, cond_n;
    logic [PC_W-1:0]  target_q, target_n;
    logic             taken_q, taken_n;
    logic [PC_W-1:0]  redirect_pc_q;
    logic             resolve_go;

    function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'b000:  cond_eval = !z;
            3'b001:  cond_eval = z;
            3'b010:  cond_eval = !z && !n;
            3'b011:  cond_eval = n;
            3'b100:  cond_eval = z || !n;
            3'b101:  cond_eval = n || z;
            3'b110:  cond_eval = v;
            default: cond_eval = 1'b1;
        endcase
    endfunction

    // Outstanding writer count. Simultaneous issue and retire cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            case ({bus.flag_wr_issue, bus.flag_en})
                2'b10:   if (pend_q != CNT_MAX) pend_q <= pend_q + CNT_ONE;
                2'b01:   if (pend_q != '0)      pend_q <= pend_q - CNT_ONE;
                default: pend_q <= pend_q;
            endcase
        end
    end

    always_comb begin
        state_n    = state_q;
        wait_n     = wait_q;
        cond_n     = cond_q;
        target_n   = target_q;
        taken_n    = taken_q;
        resolve_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.br_valid) begin
                    cond_n   = bus.br_cond;
                    target_n = bus.br_target;
                    if (bus.br_cond == 3'b111 || pend_q == '0) begin
                        resolve_go = 1'b1;
                        taken_n    = cond_eval(bus.br_cond, bus.flags);
                    end
`ifdef BR_FLAG_FWD_EN
                    else if (pend_q == CNT_ONE && bus.flag_en && !bus.flag_wr_issue) begin
                        resolve_go = 1'b1;
                        taken_n    = cond_eval(bus.br_cond, bus.flag_d);
                    end
`endif
                    else begin
                        // Only writers older than the branch are waited on;
                        // one retiring this very cycle is already accounted.
                        state_n = WAIT;
                        wait_n  = pend_q - {{(CNT_W-1){1'b0}}, bus.flag_en};
                    end
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    resolve_go = 1'b1;
                    taken_n    = cond_eval(cond_q, bus.flags);
                end
`ifdef BR_FLAG_FWD_EN
                else if (wait_q == CNT_ONE && bus.flag_en) begin
                    resolve_go = 1'b1;
                    taken_n    = cond_eval(cond_q, bus.flag_d);
                end
`endif
                else if (bus.flag_en) begin
                    wait_n = wait_q - CNT_ONE;
                end
            end
            RESOLVE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (resolve_go) begin
            state_n = RESOLVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            cond_q        <= '0;
            target_q      <= '0;
            taken_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q  <= state_n;
            wait_q   <= wait_n;
            cond_q   <= cond_n;
            target_q <= target_n;
            taken_q  <= taken_n;
            // redirect_pc only moves for taken branches so it holds otherwise.
            if (resolve_go && taken_n) begin
                redirect_pc_q <= target_n;
            end
        end
    end

`ifndef BR_FLAG_FWD_EN
    logic unused_flag_d;
    assign unused_flag_d = ^bus.flag_d;
`endif

    assign bus.br_stall       = (state_q == WAIT);
    assign bus.br_ack         = (state_q == RESOLVE);
    assign bus.br_taken       = (state_q == RESOLVE) && taken_q;
    assign bus.redirect_valid = (state_q == RESOLVE) && taken_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.issue_full     = (pend_q == CNT_MAX);
    assign state_dbg          = state_q;

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Sits directly downstream of the N/V/Z flag register. Consumes its outputs to resolve conditional branches.
- Tracks outstanding flag-writing instructions and holds each branch until the flags it depends on are architecturally valid.
- Evaluates the 3-bit condition code and issues a one-cycle PC redirect and acknowledge to fetch/decode.

Parameters:
- PC_W, 16, width of PC and target.
- CNT_W, 2, width of the outstanding flag-writer counters (max 2^CNT_W-1 in flight).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- br_valid  in  1  branch request; held stable by decode until br_ack
- br_cond  in  3  condition code
- br_target  in  PC_W  taken target
- flag_wr_issue  in  1  a flag-writing instruction enters the pipeline this cycle
- flag_en  in  1  flag register write enable this cycle (writer retires)
- flag_d  in  3  {N,V,Z} being written this cycle
- flags  in  3  flag register output {N,V,Z}
- br_stall  out  1  branch held waiting on flags
- br_ack  out  1  one-cycle pulse: branch resolved
- br_taken  out  1  valid with br_ack
- redirect_valid  out  1  one-cycle pulse = br_ack & br_taken
- redirect_pc  out  PC_W  target, valid with redirect_valid
- issue_full  out  1  pend_cnt at max; decode must not assert flag_wr_issue

Behaviour:
- Reset (async, rst=1): state IDLE; pend_cnt=0, wait_cnt=0. br_stall, br_ack, br_taken, redirect_valid, issue_full all 0; redirect_pc=0.
- pend_cnt: +1 on flag_wr_issue, -1 on flag_en, unchanged when both. Holds at 0 on flag_en at 0. Holds at max on issue at max; issue_full = (pend_cnt==max).
- Conditions on {N,V,Z}:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z&!N
  - 011 LT: N
  - 100 GE: Z|!N
  - 101 LE: N|Z
  - 110 OV: V
  - 111 always taken, independent of flags
- IDLE, br_valid=1:
  - Resolve immediately if br_cond==111 or pend_cnt==0. Evaluate on flags, capture result and br_target, go RESOLVE.
  - Otherwise go WAIT, wait_cnt <= pend_cnt - flag_en.
  - A flag_wr_issue in the same cycle is younger than the branch and is not waited on.
- WAIT:
  - br_stall=1.
  - wait_cnt decrements on each flag_en; flag_wr_issue does not affect wait_cnt.
  - When wait_cnt==0, evaluate on flags (now updated) and go RESOLVE.
- RESOLVE (one cycle): registered outputs br_ack=1, br_taken=result, redirect_valid=result, redirect_pc=captured target. Go IDLE.
- Latency:
  - No dependency: acceptance cycle + 1 → br_ack.
  - Dependency: br_ack 2 cycles after the final flag_en.
- br_valid dropped during WAIT is a protocol error; the block completes the branch anyway.
- Back-to-back branches: next branch accepted in the IDLE cycle after RESOLVE; no bubble beyond that.
- Reset mid-WAIT/RESOLVE: return to IDLE, no ack; counters cleared.
- redirect_pc holds its last value when redirect_valid=0.

Optional Feature:
- Macro BR_FLAG_FWD_EN.
- Defined: in WAIT, if wait_cnt==1 and flag_en=1, evaluate on flag_d that cycle and go RESOLVE directly. Saves one cycle. Same forwarding in IDLE when pend_cnt==1, flag_en=1, and no flag_wr_issue.
- Undefined: flag_d is ignored and the timing above applies.

Test Plan:
- Reset, br_valid with cond=111, target=0x0040, pend_cnt=0 → next cycle br_ack=1, redirect_valid=1, redirect_pc=0x0040; br_stall never high.
- flags=001 (Z), cond=001 EQ, pend_cnt=0 → br_ack, br_taken=1.
- Same setup with cond=000 NE → br_ack, br_taken=0, redirect_valid=0.
- Two flag_wr_issue, then branch cond=011 LT:
  - br_stall high.
  - flag_en #1 (flag_d=000), flag_en #2 (flag_d=100); flags=100 after the second write.
  - Without feature: br_ack 2 cycles after the 2nd flag_en with taken=1. With BR_FLAG_FWD_EN: 1 cycle after.
- During WAIT, assert flag_wr_issue plus simultaneous flag_en/flag_wr_issue → wait_cnt ignores the new issues; pend_cnt stays consistent; branch resolves after the original writers retire.
- Fill pend_cnt to 3 (CNT_W=2) → issue_full=1; an extra issue does not wrap. Then assert rst mid-WAIT → all outputs 0 immediately, state IDLE.
